// File: rtl/hmem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port among N_HARTS harts,
// with an AMO bus lock and write-invalidate broadcast to the non-writing harts.
module hmem_arbiter #(
  parameter int N_HARTS = 2,
  parameter int LINE    = 512
) (
  input  logic                    a_clk,
  input  logic                    a_rst,
  input  logic [N_HARTS*64-1:0]   h_addr,
  input  logic [N_HARTS-1:0]      h_rd,
  input  logic [N_HARTS-1:0]      h_wr,
  input  logic [N_HARTS*LINE-1:0] h_data_out,
  output logic [LINE-1:0]         h_data_in,
  output logic [N_HARTS-1:0]      h_dv,
  output logic [63:0]             h_inv_addr,
  output logic [N_HARTS-1:0]      h_inv,
  input  logic [N_HARTS-1:0]      h_amo_req,
  output logic [N_HARTS-1:0]      h_amo_ack,
  output logic [63:0]             m_addr,
  output logic                    m_rd,
  output logic                    m_wr,
  output logic [LINE-1:0]         m_data_out,
  input  logic [LINE-1:0]         m_data_in,
  input  logic                    m_dv
);
  localparam int IW = $clog2(N_HARTS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state;
  logic [IW-1:0]      rr;
  logic [IW-1:0]      lock_own;
  logic               lock_v;
  logic [N_HARTS-1:0] req;
  logic [IW-1:0]      gnt_nxt;
  logic [IW-1:0]      amo_nxt;
  logic               gnt_hit;
  logic               amo_hit;
  logic [N_HARTS-1:0] gnt_oh;
  logic [N_HARTS-1:0] amo_oh;

  always_comb begin
    for (int i = 0; i < N_HARTS; i++)
      req[i] = (h_rd[i] | h_wr[i]) & (!lock_v || lock_own == IW'(i));
  end

  // Scan offsets from farthest to nearest so the hart right after rr wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_hit = 1'b0;
    gnt_nxt = '0;
    amo_hit = 1'b0;
    amo_nxt = '0;
    for (int o = N_HARTS; o >= 1; o--) begin
      idx = (int'(rr) + o) % N_HARTS;
      if (req[idx]) begin
        gnt_hit = 1'b1;
        gnt_nxt = IW'(idx);
      end
      if (h_amo_req[idx]) begin
        amo_hit = 1'b1;
        amo_nxt = IW'(idx);
      end
    end
  end

  assign gnt_oh = N_HARTS'(1) << rr;
  assign amo_oh = N_HARTS'(1) << amo_nxt;

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state      <= IDLE;
      rr         <= IW'(N_HARTS - 1);
      lock_v     <= 1'b0;
      lock_own   <= '0;
      m_rd       <= 1'b0;
      m_wr       <= 1'b0;
      m_addr     <= '0;
      m_data_out <= '0;
      h_data_in  <= '0;
      h_dv       <= '0;
      h_inv      <= '0;
      h_inv_addr <= '0;
      h_amo_ack  <= '0;
    end else begin
      // Release is state-independent; an in-flight transaction just finishes.
      if (lock_v && !h_amo_req[lock_own]) begin
        lock_v    <= 1'b0;
        h_amo_ack <= '0;
      end
      unique case (state)
        IDLE: begin
          if (!lock_v && amo_hit) begin
            lock_v    <= 1'b1;
            lock_own  <= amo_nxt;
            h_amo_ack <= amo_oh;
          end else if (gnt_hit) begin
            rr     <= gnt_nxt;
            m_addr <= h_addr[int'(gnt_nxt)*64 +: 64];
            if (h_wr[gnt_nxt]) begin
              m_wr       <= 1'b1;
              m_data_out <= h_data_out[int'(gnt_nxt)*LINE +: LINE];
            end else begin
              m_rd <= 1'b1;
            end
            state <= BUSY;
          end
        end
        BUSY: begin
          if (m_dv) begin
            m_rd <= 1'b0;
            m_wr <= 1'b0;
            h_dv <= gnt_oh;
            if (m_wr) begin
              h_inv      <= ~gnt_oh;
              h_inv_addr <= m_addr;
            end else begin
              h_data_in <= m_data_in;
            end
            state <= RESP;
          end
        end
        RESP: begin
          h_dv  <= '0;
          h_inv <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
